// File: rtl/rgbd_vo_reg_bank.sv
// rgbd_vo_reg_bank: RGBD-VO register bank; valid/ready req (i_req_*) and rsp (o_rsp_*) bus, shadow->active commit on i_frame_start (o_cfg_update/o_cfg_pending), active config outputs o_disable..o_depth_min; optional write lock via RGBD_VO_REG_LOCK_EN
module rgbd_vo_reg_bank #(
  parameter int          DW            = 35,
  parameter logic [9:0]  H_SIZE_DEF    = 10'd640,
  parameter logic [9:0]  V_SIZE_DEF    = 10'd480,
  parameter logic [15:0] DEPTH_MAX_DEF = 16'hFFFF,
  parameter logic [15:0] DEPTH_MIN_DEF = 16'd0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [31:0]          i_req_addr,
  input  logic [DW-1:0]        i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DW-1:0]        o_rsp_rdata,
  output logic                 o_rsp_err,
  input  logic                 i_frame_start,
  output logic                 o_cfg_update,
  output logic                 o_cfg_pending,
  output logic                 o_disable,
  output logic [9:0]           o_h_size,
  output logic [9:0]           o_v_size,
  output logic signed [DW-1:0] o_fx,
  output logic signed [DW-1:0] o_fy,
  output logic signed [DW-1:0] o_cx,
  output logic signed [DW-1:0] o_cy,
  output logic [15:0]          o_depth_max,
  output logic [15:0]          o_depth_min
);
  typedef enum logic {IDLE, RSP} state_t;
  state_t        r_state;
  logic          r_req_ready, r_rsp_valid, r_rsp_err, r_update, r_pending, r_disable;
  logic [DW-1:0] r_rsp_rdata;
  logic [9:0]    r_sh_h, r_sh_v, r_h, r_v;
  logic [DW-1:0] r_sh_fx, r_sh_fy, r_sh_cx, r_sh_cy, r_fx, r_fy, r_cx, r_cy;
  logic [15:0]   r_sh_dmax, r_sh_dmin, r_dmax, r_dmin;
  logic          w_acc, w_is_reg, w_is_field, w_lock, w_err, w_wr;
  logic [DW-1:0] w_rdata;
  assign w_acc      = i_req_valid && r_req_ready;
  assign w_is_reg   = i_req_addr < 32'd10;
  assign w_is_field = (i_req_addr >= 32'd1) && (i_req_addr <= 32'd8);
`ifdef RGBD_VO_REG_LOCK_EN
  assign w_lock = i_req_write && w_is_field && !r_disable;
`else
  assign w_lock = 1'b0;
`endif
  assign w_err = !w_is_reg || w_lock;
  assign w_wr  = w_acc && i_req_write && !w_err;
  always_comb begin
    w_rdata = '0;
    case (i_req_addr)
      32'd0:   w_rdata = DW'(r_disable);
      32'd1:   w_rdata = DW'(r_sh_h);
      32'd2:   w_rdata = DW'(r_sh_v);
      32'd3:   w_rdata = r_sh_fx;
      32'd4:   w_rdata = r_sh_fy;
      32'd5:   w_rdata = r_sh_cx;
      32'd6:   w_rdata = r_sh_cy;
      32'd7:   w_rdata = DW'(r_sh_dmax);
      32'd8:   w_rdata = DW'(r_sh_dmin);
      default: w_rdata = '0;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_update    <= 1'b0;
      r_pending   <= 1'b0;
      r_disable   <= 1'b1;
      r_sh_h      <= H_SIZE_DEF;
      r_sh_v      <= V_SIZE_DEF;
      r_sh_fx     <= '0;
      r_sh_fy     <= '0;
      r_sh_cx     <= '0;
      r_sh_cy     <= '0;
      r_sh_dmax   <= DEPTH_MAX_DEF;
      r_sh_dmin   <= DEPTH_MIN_DEF;
      r_h         <= H_SIZE_DEF;
      r_v         <= V_SIZE_DEF;
      r_fx        <= '0;
      r_fy        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_dmax      <= DEPTH_MAX_DEF;
      r_dmin      <= DEPTH_MIN_DEF;
    end else begin
      r_update <= i_frame_start;
      // the commit reads the shadow before any same-cycle write lands in it
      if (i_frame_start) begin
        r_h    <= r_sh_h;
        r_v    <= r_sh_v;
        r_fx   <= r_sh_fx;
        r_fy   <= r_sh_fy;
        r_cx   <= r_sh_cx;
        r_cy   <= r_sh_cy;
        r_dmax <= r_sh_dmax;
        r_dmin <= r_sh_dmin;
      end
      if (w_wr) begin
        case (i_req_addr)
          32'd0:   r_disable <= i_req_wdata[0];
          32'd1:   r_sh_h    <= i_req_wdata[9:0];
          32'd2:   r_sh_v    <= i_req_wdata[9:0];
          32'd3:   r_sh_fx   <= i_req_wdata;
          32'd4:   r_sh_fy   <= i_req_wdata;
          32'd5:   r_sh_cx   <= i_req_wdata;
          32'd6:   r_sh_cy   <= i_req_wdata;
          32'd7:   r_sh_dmax <= i_req_wdata[15:0];
          32'd8:   r_sh_dmin <= i_req_wdata[15:0];
          default: ;
        endcase
      end
      if (w_wr && w_is_field) r_pending <= 1'b1;
      else if (i_frame_start) r_pending <= 1'b0;
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_state     <= RSP;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_err;
          r_rsp_rdata <= i_req_write ? '0 : w_rdata;
        end
        RSP: if (i_rsp_ready) begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_cfg_update  = r_update;
  assign o_cfg_pending = r_pending;
  assign o_disable     = r_disable;
  assign o_h_size      = r_h;
  assign o_v_size      = r_v;
  assign o_fx          = r_fx;
  assign o_fy          = r_fy;
  assign o_cx          = r_cx;
  assign o_cy          = r_cy;
  assign o_depth_max   = r_dmax;
  assign o_depth_min   = r_dmin;
endmodule

// File: tb/tb_rgbd_vo_reg_bank.sv
// tb_rgbd_vo_reg_bank: scoreboard bench for rgbd_vo_reg_bank against an address-indexed register model
module tb_rgbd_vo_reg_bank;
  logic        clk = 0, rst = 1;
  logic        i_req_valid = 0, i_req_write = 0, i_rsp_ready = 1, i_frame_start = 0;
  logic [31:0] i_req_addr = 0;
  logic [34:0] i_req_wdata = 0;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_cfg_update, o_cfg_pending, o_disable;
  logic [34:0] o_rsp_rdata;
  logic [9:0]  o_h_size, o_v_size;
  logic signed [34:0] o_fx, o_fy, o_cx, o_cy;
  logic [15:0] o_depth_max, o_depth_min;
  rgbd_vo_reg_bank dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .i_frame_start(i_frame_start), .o_cfg_update(o_cfg_update),
    .o_cfg_pending(o_cfg_pending), .o_disable(o_disable), .o_h_size(o_h_size),
    .o_v_size(o_v_size), .o_fx(o_fx), .o_fy(o_fy), .o_cx(o_cx), .o_cy(o_cy),
    .o_depth_max(o_depth_max), .o_depth_min(o_depth_min)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [35:0] q[$];
  logic [34:0] sh[0:9], act[0:9];
  logic        m_dis, m_pend;
  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
  endtask
  function automatic logic [34:0] fmask(input int a);
    return (a == 1 || a == 2) ? 35'h3FF : (a == 7 || a == 8) ? 35'hFFFF : {35{1'b1}};
  endfunction
  task automatic reset_model();
    sh = '{35'd1, 35'd640, 35'd480, 35'd0, 35'd0, 35'd0, 35'd0, 35'hFFFF, 35'd0, 35'd0};
    act = sh;
    m_dis = 1;
    m_pend = 0;
  endtask
  task automatic commit();
    for (int i = 1; i <= 8; i++) act[i] = sh[i];
    m_pend = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 64'(o_rsp_valid), 64'(0));
      else begin
        logic [35:0] e;
        e = q.pop_front();
        chk("rsp_err", 64'(o_rsp_err), 64'(e[35]));
        chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e[34:0]));
      end
    end
  end
  task automatic check_active();
    @(negedge clk);
    chk("o_disable", 64'(o_disable), 64'(m_dis));
    chk("o_cfg_pending", 64'(o_cfg_pending), 64'(m_pend));
    chk("o_h_size", 64'(o_h_size), 64'(act[1][9:0]));
    chk("o_v_size", 64'(o_v_size), 64'(act[2][9:0]));
    chk("o_fx", {29'd0, o_fx}, 64'(act[3]));
    chk("o_fy", {29'd0, o_fy}, 64'(act[4]));
    chk("o_cx", {29'd0, o_cx}, 64'(act[5]));
    chk("o_cy", {29'd0, o_cy}, 64'(act[6]));
    chk("o_depth_max", 64'(o_depth_max), 64'(act[7][15:0]));
    chk("o_depth_min", 64'(o_depth_min), 64'(act[8][15:0]));
  endtask
  task automatic op(input logic wr, input logic [31:0] a, input logic [34:0] d, input logic fs, input int stall);
    logic [34:0] er;
    logic ee, lk;
    int ai;
    @(negedge clk);
    chk("req_ready_idle", 64'(o_req_ready), 64'(1));
    i_req_valid = 1; i_req_write = wr; i_req_addr = a; i_req_wdata = d; i_frame_start = fs;
    if (stall > 0) i_rsp_ready = 0;
    ai = (a < 10) ? int'(a) : 10;
    lk = 0;
`ifdef RGBD_VO_REG_LOCK_EN
    lk = wr && ai >= 1 && ai <= 8 && !m_dis;
`endif
    ee = (ai == 10) || lk;
    er = 0;
    if (!wr && ai == 0) er = 35'(m_dis);
    else if (!wr && ai >= 1 && ai <= 8) er = sh[ai];
    q.push_back({ee, er});
    if (fs) commit();
    if (wr && !ee) begin
      if (ai == 0) m_dis = d[0];
      else if (ai <= 8) begin sh[ai] = d & fmask(ai); m_pend = 1; end
    end
    @(posedge clk);
    #1 i_req_valid = 0; i_frame_start = 0;
    chk("cfg_update_pulse", 64'(o_cfg_update), 64'(fs));
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", 64'(o_rsp_valid), 64'(1));
        chk("stall_rdata", 64'(o_rsp_rdata), 64'(er));
        chk("stall_req_ready", 64'(o_req_ready), 64'(0));
      end
      @(posedge clk);
      #1 i_rsp_ready = 1;
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("rsp_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
    check_active();
  endtask
  task automatic frame();
    @(negedge clk);
    i_frame_start = 1;
    commit();
    @(posedge clk);
    #1 i_frame_start = 0;
    chk("cfg_update_frame", 64'(o_cfg_update), 64'(1));
  endtask
  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(o_req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("rst_cfg_update", 64'(o_cfg_update), 64'(0));
    @(negedge clk) rst = 0;
    check_active();
    for (int a = 0; a <= 10; a++) op(0, a, 0, 0, 0);
    op(1, 3, 35'h1_2345_6789, 0, 0);
    op(0, 3, 0, 0, 0);
    frame();
    check_active();
    op(1, 1, 35'hFFF, 0, 0);
    op(0, 1, 0, 0, 0);
    op(1, 0, 0, 0, 0);
    op(1, 8, 35'd100, 1, 0);
    frame();
    check_active();
    frame();
    frame();
    check_active();
    op(1, 5, 35'd5, 0, 0);
    op(0, 5, 0, 0, 0);
    op(1, 0, 35'd1, 0, 0);
    op(1, 5, 35'd5, 0, 0);
    op(0, 5, 0, 0, 0);
    op(1, 9, 35'h7_FFFF_FFFF, 0, 0);
    op(0, 9, 0, 0, 0);
    op(1, 32'hFFFF_0002, 35'd7, 0, 0);
    op(0, 2, 0, 0, 3);
    @(negedge clk);
    i_req_valid = 1; i_req_write = 0; i_req_addr = 2; i_rsp_ready = 0;
    @(posedge clk);
    #1 i_req_valid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 64'(o_rsp_valid), 64'(1));
      chk("hold_rdata", 64'(o_rsp_rdata), 64'(480));
      chk("hold_req_ready", 64'(o_req_ready), 64'(0));
    end
    #1 rst = 1;
    #1;
    chk("rst_drop_valid", 64'(o_rsp_valid), 64'(0));
    chk("rst_drop_ready", 64'(o_req_ready), 64'(1));
    reset_model();
    @(negedge clk);
    rst = 0; i_rsp_ready = 1;
    check_active();
    for (int n = 0; n < 300; n++) begin
      logic [63:0] t;
      logic [31:0] a;
      t = {$urandom, $urandom};
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) begin
        frame();
        check_active();
      end
      op(1'($urandom_range(0, 1)), a, t[34:0], 1'($urandom_range(0, 5) == 0),
         ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
